// File: rtl/render_frame_scheduler.sv
// Multi-buffered frame scheduler: launches RenderFrame into a free SRAM framebuffer,
// tracks completion and promotes finished frames to scan-out on vsync.
module render_frame_scheduler #(
  parameter int NUM_BUFFERS = 2,
  parameter int ADDR_WIDTH  = 20,
  parameter int FRAME_WORDS = 76800,
  parameter int COORD_WIDTH = 18,
  parameter int CONTINUOUS  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       request_frame,
  input  logic [15*COORD_WIDTH-1:0]  scene_in,
  output logic [15*COORD_WIDTH-1:0]  scene_out,
  output logic                       begin_frame,
  input  logic                       completed_frame,
  output logic [ADDR_WIDTH-1:0]      SRAM_address_offset,
  input  logic                       vsync,
  output logic [ADDR_WIDTH-1:0]      display_offset,
  output logic                       busy,
  output logic [7:0]                 frames_dropped
);

  if ((NUM_BUFFERS < 2) || (NUM_BUFFERS > 4)) begin : g_bad_num_buffers
    $error("render_frame_scheduler: NUM_BUFFERS must be in 2..4");
  end
  if ((64'(NUM_BUFFERS) * 64'(FRAME_WORDS)) > (64'd1 << ADDR_WIDTH)) begin : g_bad_frame_size
    $error("render_frame_scheduler: framebuffers do not fit in the SRAM address space");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RENDER = 2'd2
  } state_t;

  function automatic logic [ADDR_WIDTH-1:0] buf_offset(input logic [1:0] idx);
    buf_offset = ADDR_WIDTH'(idx) * ADDR_WIDTH'(FRAME_WORDS);
  endfunction

  state_t                      state_q, state_d;
  logic                        req_q, req_d;
  logic                        comp_prev_q, comp_prev_d;
  logic                        comp_rise_q, comp_rise_d;
  logic [1:0]                  disp_idx_q, disp_idx_d;
  logic                        pend_valid_q, pend_valid_d;
  logic [1:0]                  pend_idx_q, pend_idx_d;
  logic                        rend_valid_q, rend_valid_d;
  logic [1:0]                  rend_idx_q, rend_idx_d;
  logic                        begin_frame_q, begin_frame_d;
  logic                        busy_q, busy_d;
  logic [7:0]                  drops_q, drops_d;
  logic [ADDR_WIDTH-1:0]       sram_off_q, sram_off_d;
  logic [ADDR_WIDTH-1:0]       disp_off_q, disp_off_d;
  logic [15*COORD_WIDTH-1:0]   scene_q, scene_d;

  logic [NUM_BUFFERS-1:0]      buf_free_s;
  logic                        free_found_s;
  logic [1:0]                  free_idx_s;
  logic                        launch_s;
  logic                        done_s;

  // A buffer is free when it holds no role; the lowest-index free one wins.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = 2'd0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      buf_free_s[i] = !((2'(i) == disp_idx_q) ||
                        (pend_valid_q && (2'(i) == pend_idx_q)) ||
                        (rend_valid_q && (2'(i) == rend_idx_q)));
    end
    for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
      if (buf_free_s[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = 2'(i);
      end else begin
        free_found_s = free_found_s;
        free_idx_s   = free_idx_s;
      end
    end
  end

  // Next-state, buffer-role bookkeeping and registered output values.
  always_comb begin
    state_d       = state_q;
    rend_valid_d  = rend_valid_q;
    rend_idx_d    = rend_idx_q;
    disp_idx_d    = disp_idx_q;
    pend_valid_d  = pend_valid_q;
    pend_idx_d    = pend_idx_q;
    drops_d       = drops_q;
    sram_off_d    = sram_off_q;
    disp_off_d    = disp_off_q;
    scene_d       = scene_q;
    begin_frame_d = 1'b0;
    launch_s      = 1'b0;
    done_s        = 1'b0;

    // Rising edges only matter while rendering; edges elsewhere are dropped here.
    comp_prev_d = completed_frame;
    comp_rise_d = completed_frame && !comp_prev_q && (state_q == ST_RENDER);

    case (state_q)
      ST_IDLE: begin
        if ((req_q || (CONTINUOUS != 0)) && free_found_s) begin
          launch_s      = 1'b1;
          state_d       = ST_START;
          rend_valid_d  = 1'b1;
          rend_idx_d    = free_idx_s;
          sram_off_d    = buf_offset(free_idx_s);
          scene_d       = scene_in;
          begin_frame_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_RENDER;
      end
      ST_RENDER: begin
        if (comp_rise_q) begin
          done_s       = 1'b1;
          state_d      = ST_IDLE;
          rend_valid_d = 1'b0;
        end else begin
          state_d = ST_RENDER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // vsync consumes the pending buffer as it stood before this edge.
    if (vsync && pend_valid_q) begin
      disp_idx_d   = pend_idx_q;
      disp_off_d   = buf_offset(pend_idx_q);
      pend_valid_d = 1'b0;
    end else begin
      disp_idx_d = disp_idx_q;
    end

    if (done_s) begin
      if (pend_valid_q && !vsync && (drops_q != 8'hFF)) begin
        drops_d = drops_q + 8'd1;
      end else begin
        drops_d = drops_q;
      end
      pend_valid_d = 1'b1;
      pend_idx_d   = rend_idx_q;
    end else begin
      pend_idx_d = pend_idx_q;
    end

    if (CONTINUOUS != 0) begin
      req_d = 1'b0;
    end else begin
      req_d = request_frame || (req_q && !launch_s);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= 1'b0;
      comp_prev_q   <= 1'b1;
      comp_rise_q   <= 1'b0;
      disp_idx_q    <= 2'd0;
      pend_valid_q  <= 1'b0;
      pend_idx_q    <= 2'd0;
      rend_valid_q  <= 1'b0;
      rend_idx_q    <= 2'd0;
      begin_frame_q <= 1'b0;
      busy_q        <= 1'b0;
      drops_q       <= 8'd0;
      sram_off_q    <= '0;
      disp_off_q    <= '0;
      scene_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      comp_prev_q   <= comp_prev_d;
      comp_rise_q   <= comp_rise_d;
      disp_idx_q    <= disp_idx_d;
      pend_valid_q  <= pend_valid_d;
      pend_idx_q    <= pend_idx_d;
      rend_valid_q  <= rend_valid_d;
      rend_idx_q    <= rend_idx_d;
      begin_frame_q <= begin_frame_d;
      busy_q        <= busy_d;
      drops_q       <= drops_d;
      sram_off_q    <= sram_off_d;
      disp_off_q    <= disp_off_d;
      scene_q       <= scene_d;
    end
  end

  assign scene_out           = scene_q;
  assign begin_frame         = begin_frame_q;
  assign SRAM_address_offset = sram_off_q;
  assign display_offset      = disp_off_q;
  assign busy                = busy_q;
  assign frames_dropped      = drops_q;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Scoreboard bench for render_frame_scheduler: three configurations (2/manual, 2/continuous,
// 3/continuous); expected launches and display changes are queued, a monitor pops and compares.
module tb_render_frame_scheduler;

  localparam int FW = 76800;
  localparam int SW = 270;

  typedef struct {
    int          inst;
    logic [19:0] off;
    logic [269:0] scene;
  } launch_t;

  typedef struct {
    int          inst;
    logic [19:0] off;
  } disp_t;

  logic         clk;
  logic         rst     [3];
  logic         req     [3];
  logic         comp    [3];
  logic         vs      [3];
  logic [269:0] scene_i [3];
  logic [269:0] scene_o [3];
  logic         bf      [3];
  logic [19:0]  sram    [3];
  logic [19:0]  disp    [3];
  logic         busy    [3];
  logic [7:0]   drop    [3];
  logic [19:0]  disp_prev [3];

  launch_t launch_q[$];
  disp_t   disp_q[$];

  int errors = 0;
  int checks = 0;

  render_frame_scheduler #(.NUM_BUFFERS(2), .CONTINUOUS(0)) u_a (
    .clock(clk), .reset(rst[0]), .request_frame(req[0]), .scene_in(scene_i[0]),
    .scene_out(scene_o[0]), .begin_frame(bf[0]), .completed_frame(comp[0]),
    .SRAM_address_offset(sram[0]), .vsync(vs[0]), .display_offset(disp[0]),
    .busy(busy[0]), .frames_dropped(drop[0]));

  render_frame_scheduler #(.NUM_BUFFERS(2), .CONTINUOUS(1)) u_b (
    .clock(clk), .reset(rst[1]), .request_frame(req[1]), .scene_in(scene_i[1]),
    .scene_out(scene_o[1]), .begin_frame(bf[1]), .completed_frame(comp[1]),
    .SRAM_address_offset(sram[1]), .vsync(vs[1]), .display_offset(disp[1]),
    .busy(busy[1]), .frames_dropped(drop[1]));

  render_frame_scheduler #(.NUM_BUFFERS(3), .CONTINUOUS(1)) u_c (
    .clock(clk), .reset(rst[2]), .request_frame(req[2]), .scene_in(scene_i[2]),
    .scene_out(scene_o[2]), .begin_frame(bf[2]), .completed_frame(comp[2]),
    .SRAM_address_offset(sram[2]), .vsync(vs[2]), .display_offset(disp[2]),
    .busy(busy[2]), .frames_dropped(drop[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [269:0] act, input logic [269:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [269:0] mk_scene(input int k);
    logic [269:0] s;
    for (int c = 0; c < 15; c++) s[c*18 +: 18] = 18'(k * 1000 + c * 7 + 1);
    return s;
  endfunction

  task automatic push_launch(input int i, input int off, input logic [269:0] sc);
    launch_t e;
    e.inst = i; e.off = 20'(off); e.scene = sc;
    launch_q.push_back(e);
  endtask

  task automatic push_disp(input int i, input int off);
    disp_t e;
    e.inst = i; e.off = 20'(off);
    disp_q.push_back(e);
  endtask

  // Monitor: compares every launch and every display change against the queues.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i] === 1'b0) begin
        if (bf[i] === 1'b1) begin
          int idx;
          idx = -1;
          for (int j = launch_q.size() - 1; j >= 0; j--) if (launch_q[j].inst == i) idx = j;
          if (idx < 0) begin
            checks++; errors++;
            $display("FAIL unexpected_launch inst=%0d: got begin_frame at offset %0d, expected none", i, sram[i]);
          end else begin
            chk($sformatf("launch_offset inst=%0d", i), 270'(sram[i]), 270'(launch_q[idx].off));
            chk($sformatf("launch_scene inst=%0d", i), scene_o[i], launch_q[idx].scene);
            launch_q.delete(idx);
          end
        end
        if (disp[i] !== disp_prev[i]) begin
          int idx;
          idx = -1;
          for (int j = disp_q.size() - 1; j >= 0; j--) if (disp_q[j].inst == i) idx = j;
          if (idx < 0) begin
            checks++; errors++;
            $display("FAIL unexpected_display inst=%0d: got %0d, expected no change from %0d", i, disp[i], disp_prev[i]);
          end else begin
            chk($sformatf("display_offset inst=%0d", i), 270'(disp[i]), 270'(disp_q[idx].off));
            disp_q.delete(idx);
          end
        end
      end
      disp_prev[i] <= disp[i];
    end
  end

  task automatic wait_begin(input int i);
    int n;
    n = 0;
    while (bf[i] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bf[i] !== 1'b1) begin
      errors++;
      $display("FAIL wait_begin inst=%0d: got no begin_frame in 60 cycles, expected a launch", i);
    end
  endtask

  task automatic pulse_req(input int i);
    @(posedge clk); #1 req[i] = 1'b1;
    @(posedge clk); #1 req[i] = 1'b0;
  endtask

  task automatic pulse_vsync(input int i);
    @(posedge clk); #1 vs[i] = 1'b1;
    @(posedge clk); #1 vs[i] = 1'b0;
  endtask

  task automatic complete(input int i);
    int n;
    @(posedge clk); #1 comp[i] = 1'b1;
    @(posedge clk); #1 comp[i] = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy[i] !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("complete_busy_low inst=%0d", i), 270'(busy[i]), 270'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; comp[i] = 1'b0; vs[i] = 1'b0; scene_i[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("a_reset_busy",  270'(busy[0]), 270'(0));
    chk("a_reset_begin", 270'(bf[0]),   270'(0));
    chk("a_reset_sram",  270'(sram[0]), 270'(0));
    chk("a_reset_disp",  270'(disp[0]), 270'(0));
    chk("a_reset_drops", 270'(drop[0]), 270'(0));
    chk("a_reset_scene", scene_o[0], 270'(0));

    // Manual launch latency: begin_frame only in the START cycle.
    scene_i[0] = mk_scene(1);
    push_launch(0, FW, mk_scene(1));
    pulse_req(0);
    @(negedge clk);
    chk("a_lat_begin_early", 270'(bf[0]), 270'(0));
    chk("a_lat_busy_early",  270'(busy[0]), 270'(0));
    @(negedge clk);
    chk("a_lat_begin",  270'(bf[0]),   270'(1));
    chk("a_lat_sram",   270'(sram[0]), 270'(FW));
    chk("a_lat_busy",   270'(busy[0]), 270'(1));
    @(negedge clk);
    chk("a_begin_one_cycle", 270'(bf[0]),   270'(0));
    chk("a_busy_render",     270'(busy[0]), 270'(1));
    repeat (3) @(negedge clk);
    @(posedge clk); #1 comp[0] = 1'b1;
    @(posedge clk); #1 comp[0] = 1'b0;
    @(negedge clk);
    chk("a_busy_before_done", 270'(busy[0]), 270'(1));
    @(negedge clk);
    chk("a_busy_after_done",  270'(busy[0]), 270'(0));

    push_disp(0, FW);
    pulse_vsync(0);
    @(negedge clk);
    chk("a_disp_after_vsync", 270'(disp[0]), 270'(FW));

    // Second frame lands in buffer 0, which vsync just freed.
    scene_i[0] = mk_scene(2);
    push_launch(0, 0, mk_scene(2));
    pulse_req(0);
    wait_begin(0);
    complete(0);
    push_disp(0, 0);
    pulse_vsync(0);
    @(negedge clk);
    chk("a_disp_second", 270'(disp[0]), 270'(0));

    // Two requests during RENDER collapse to one extra frame.
    scene_i[0] = mk_scene(3);
    push_launch(0, FW, mk_scene(3));
    pulse_req(0);
    wait_begin(0);
    pulse_req(0);
    pulse_req(0);
    scene_i[0] = mk_scene(4);
    @(negedge clk);
    chk("a_scene_hold", scene_o[0], mk_scene(3));
    @(posedge clk); #1 comp[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("a_done_held_busy", 270'(busy[0]), 270'(0));
    push_disp(0, FW);
    push_launch(0, 0, mk_scene(4));
    pulse_vsync(0);
    wait_begin(0);
    repeat (10) @(negedge clk);
    chk("a_no_spurious_completion", 270'(busy[0]), 270'(1));
    @(posedge clk); #1 rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("a_rst2_busy",  270'(busy[0]), 270'(0));
    chk("a_rst2_disp",  270'(disp[0]), 270'(0));
    chk("a_rst2_sram",  270'(sram[0]), 270'(0));
    chk("a_rst2_drops", 270'(drop[0]), 270'(0));
    repeat (5) @(negedge clk);
    chk("a_rst2_idle", 270'(busy[0]), 270'(0));
    comp[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Continuous, two buffers: stalls until vsync frees a buffer.
    scene_i[1] = mk_scene(5);
    push_launch(1, FW, mk_scene(5));
    @(posedge clk); #1 rst[1] = 1'b0;
    wait_begin(1);
    repeat (2) @(negedge clk);
    complete(1);
    repeat (20) @(negedge clk);
    chk("b_stall_idle", 270'(busy[1]), 270'(0));
    scene_i[1] = mk_scene(6);
    push_disp(1, FW);
    push_launch(1, 0, mk_scene(6));
    @(posedge clk); #1 vs[1] = 1'b1;
    @(posedge clk); #1 vs[1] = 1'b0;
    @(negedge clk);
    chk("b_vsync_begin_low", 270'(bf[1]), 270'(0));
    @(negedge clk);
    chk("b_start_after_vsync", 270'(bf[1]), 270'(1));
    repeat (3) @(negedge clk);

    // Continuous, three buffers: runs ahead and drops frames.
    scene_i[2] = mk_scene(7);
    push_launch(2, FW, mk_scene(7));
    push_launch(2, 2*FW, mk_scene(7));
    push_launch(2, FW, mk_scene(7));
    push_launch(2, 2*FW, mk_scene(7));
    push_launch(2, FW, mk_scene(7));
    @(posedge clk); #1 rst[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_begin(2);
      repeat (2) @(negedge clk);
      complete(2);
      chk($sformatf("c_drops_after_%0d", k + 1), 270'(drop[2]), 270'(k));
    end
    wait_begin(2);
    chk("c_drops_total", 270'(drop[2]), 270'(3));

    // Completion and vsync on the same edge: old pending shown, no drop.
    push_disp(2, 2*FW);
    @(posedge clk); #1 comp[2] = 1'b1;
    @(posedge clk); #1 comp[2] = 1'b0; vs[2] = 1'b1;
    @(posedge clk); #1 vs[2] = 1'b0;
    @(negedge clk);
    chk("c_same_cycle_drops", 270'(drop[2]), 270'(3));
    chk("c_same_cycle_disp",  270'(disp[2]), 270'(2*FW));
    push_launch(2, 0, mk_scene(7));
    wait_begin(2);
    push_disp(2, FW);
    pulse_vsync(2);
    @(negedge clk);
    chk("c_next_vsync_disp",  270'(disp[2]), 270'(FW));
    chk("c_final_drops",      270'(drop[2]), 270'(3));

    repeat (5) @(negedge clk);
    chk("launch_queue_drained",  270'(launch_q.size()), 270'(0));
    chk("display_queue_drained", 270'(disp_q.size()),   270'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
